// File: rtl/mips_cpu_data_bridge.sv
// mips_cpu_data_bridge
// Bridges a single-cycle MIPS CPU data port onto an Avalon-MM style bus.
// The CPU is stalled through cpu_clk_enable while a bus access is in flight.
// A BUSY timeout turns a hung bus into an error instead of a deadlock.

module mips_cpu_data_bridge #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en_in,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [31:0] cpu_address,
   input  logic [3:0]  cpu_byteenable,
   input  logic [31:0] cpu_writedata,
   output logic [31:0] cpu_readdata,
   output logic        cpu_clk_enable,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [3:0]  avm_byteenable,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        bus_error
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Timeout fires on the last permitted BUSY cycle, so BUSY lasts exactly TIMEOUT_CYCLES.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state;
   logic        cmd_rd;
   logic        cmd_wr;
   logic [31:0] readdata;
   logic [15:0] tmo_cnt;
   logic        request;
   logic        req_err;

   assign request = (cpu_read | cpu_write) & en_in;
   // Read+write together is resolved as a write; misalignment is flagged and dropped to the word.
   assign req_err = (cpu_read & cpu_write) | (|cpu_address[1:0]);

   // Commands are decoded from state so an async reset removes them immediately.
   assign avm_read     = (state == BUSY) & cmd_rd;
   assign avm_write    = (state == BUSY) & cmd_wr;
   assign cpu_readdata = readdata;

   // CPU stall: held low while an access is pending or in flight.
   always_comb begin
      cpu_clk_enable = en_in;
      case (state)
         IDLE:    cpu_clk_enable = en_in & ~request;
         BUSY:    cpu_clk_enable = 1'b0;
         default: cpu_clk_enable = en_in;
      endcase
   end

   // Access FSM, request latch, response capture and timeout.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         cmd_rd         <= 1'b0;
         cmd_wr         <= 1'b0;
         avm_address    <= 32'd0;
         avm_byteenable <= 4'd0;
         avm_writedata  <= 32'd0;
         readdata       <= 32'd0;
         tmo_cnt        <= 16'd0;
         bus_error      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (request) begin
                  if (req_err) bus_error <= 1'b1;
                  if (|cpu_byteenable) begin
                     avm_address    <= {cpu_address[31:2], 2'b00};
                     avm_byteenable <= cpu_byteenable;
                     avm_writedata  <= cpu_writedata;
                     cmd_wr         <= cpu_write;
                     cmd_rd         <= cpu_read & ~cpu_write;
                     tmo_cnt        <= 16'd0;
                     state          <= BUSY;
                  end else begin
                     // No lanes enabled: complete without touching the bus.
                     readdata <= 32'd0;
                     state    <= DONE;
                  end
               end
            end
            BUSY: begin
               if (!avm_waitrequest) begin
                  if (cmd_rd) readdata <= avm_readdata;
                  state <= DONE;
               end else if (tmo_cnt == TMO_LAST) begin
                  bus_error <= 1'b1;
                  readdata  <= 32'hDEADBEEF;
                  state     <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            DONE: begin
               if (en_in) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mips_cpu_data_bridge.md
MIPS_CPU_DATA_BRIDGE -- requirements
Module: mips_cpu_data_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, maximum BUSY cycles before abort (legal range 1..65535).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 forces reset state immediately, independent of clk.
REQ-004 en_in  in  1  external clock enable from bench/system.
REQ-005 cpu_read  in  1  CPU data read request (combinational from CPU).
REQ-006 cpu_write  in  1  CPU data write request.
REQ-007 cpu_address  in  32  CPU byte address.
REQ-008 cpu_byteenable  in  4  CPU byte lanes.
REQ-009 cpu_writedata  in  32  CPU store data.
REQ-010 cpu_readdata  out  32  load data returned to CPU.
REQ-011 cpu_clk_enable  out  1  clock enable driven to CPU; 0 = CPU stalled.
REQ-012 avm_address  out  32  bus word address, bits [1:0] always 0.
REQ-013 avm_read / avm_write  out  1 each  bus commands.
REQ-014 avm_byteenable  out  4; avm_writedata  out  32  registered copies of CPU request.
REQ-015 avm_readdata  in  32; avm_waitrequest  in  1  bus response/stall.
REQ-016 bus_error  out  1  sticky error flag.

Function
REQ-017 The block SHALL implement FSM states IDLE, BUSY, DONE.
REQ-018 IDLE: request = (cpu_read|cpu_write) & en_in; on request with cpu_byteenable != 0, SHALL latch address, byteenable, writedata and command, then enter BUSY.
REQ-019 IDLE with request and cpu_byteenable == 0: SHALL enter DONE directly, no bus command, captured readdata 0.
REQ-020 cpu_read & cpu_write together: SHALL be treated as write and SHALL set bus_error.
REQ-021 cpu_address[1:0] != 0 on request: SHALL set bus_error; access proceeds at aligned word.
REQ-022 BUSY: avm_read/avm_write SHALL be asserted from latched command and held with all avm_* outputs stable until a cycle with avm_waitrequest = 0.
REQ-023 BUSY with avm_waitrequest = 0: SHALL capture avm_readdata (reads) into the readdata register and enter DONE next edge.
REQ-024 BUSY timeout counter SHALL count cycles in BUSY; when count reaches TIMEOUT_CYCLES with waitrequest still 1, SHALL deassert command, set bus_error, capture 32'hDEADBEEF, enter DONE.
REQ-025 DONE: no bus command; SHALL return to IDLE on the edge where en_in = 1, else remain in DONE.
REQ-026 cpu_clk_enable SHALL be 0 in BUSY and in IDLE when request present; SHALL equal en_in in DONE and in IDLE without request.
REQ-027 cpu_readdata SHALL always drive the readdata register (holds last captured value).
REQ-028 Zero-wait access latency: request cycle 0 -> command cycle 1 -> DONE cycle 2 -> CPU advances at end of cycle 2 (2 stall cycles); each wait cycle adds one.
REQ-029 en_in changes in BUSY SHALL NOT affect the bus transaction.
REQ-030 bus_error SHALL remain 1 until reset.

Reset
REQ-031 During reset = 0: state IDLE, avm_read = avm_write = 0, avm_address = 0, avm_byteenable = 0, avm_writedata = 0, readdata register = 0, timeout counter = 0, bus_error = 0.
REQ-032 Reset assertion mid-BUSY SHALL drop avm_read/avm_write asynchronously in the same cycle; transaction is abandoned.
REQ-033 After reset release, first FSM transition SHALL occur on the first rising edge with reset = 1.

Verification
REQ-034 Read 0x00000104, be 4'hF, waitrequest 0 -> avm_read high 1 cycle, avm_address 0x00000104, cpu_readdata = avm_readdata in DONE, cpu_clk_enable 0 for 2 cycles.
REQ-035 Write 0x12345678 to 0x00000200, be 4'b0011, waitrequest high 3 cycles -> avm_write held 4 cycles with stable data/byteenable, 5 stall cycles.
REQ-036 Read with waitrequest stuck 1, TIMEOUT_CYCLES = 4 -> abort after 4 BUSY cycles, bus_error 1, cpu_readdata 0xDEADBEEF.
REQ-037 cpu_read & cpu_write both 1 -> write issued, bus_error 1; cpu_address 0x00000103 -> avm_address 0x00000100, bus_error 1.
REQ-038 reset driven 0 mid-BUSY between clock edges -> avm_read 0 immediately, state IDLE, all outputs at reset values.
REQ-039 en_in = 0 in DONE for 3 cycles -> stays DONE, cpu_clk_enable 0, no new bus command; en_in = 1 -> returns IDLE.
